prince_sbox_cms_pipe: RTL and testbench

//  Pipelined, first-order CMS-masked PRINCE S-box layer: N_SBOX nibbles in 2 Boolean shares.

---
 rtl/prince_cms_pkg.sv | 39 +++
 rtl/prince_sbox_cms_expand.sv | 41 ++++
 rtl/prince_sbox_cms_pipe.sv | 80 ++++++++
 tb/tb_prince_sbox_cms_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prince_cms_pkg.sv
// Shared constants for the masked PRINCE S-box: sizes, S / S^-1 tables and their
// algebraic normal form, from which the share expansion is derived.
package prince_cms_pkg;

  localparam int NIBBLE  = 4;
  localparam int N_IN_SH = 2;
  localparam int N_EXP   = 16;
  localparam int N_MONO  = 16;

  // Entry i of each table occupies bits [4i+3:4i].
  localparam logic [63:0] SBOX_FWD = 64'h4D5E_0876_19CA_23FB;
  localparam logic [63:0] SBOX_INV = 64'h1CE5_046A_98DF_237B;

  // Moebius transform: coefficient of monomial m (bit v set = variable v present)
  // in output bit b is returned at position 16*b+m.
  function automatic logic [63:0] anf_of(input logic [63:0] tbl);
    logic [63:0] coef;
    logic        acc;
    coef = '0;
    for (int b = 0; b < NIBBLE; b++) begin
      for (int m = 0; m < N_MONO; m++) begin
        acc = 1'b0;
        for (int u = 0; u < N_MONO; u++)
          if ((u & ~m) == 0) acc ^= tbl[4*u+b];
        coef[16*b+m] = acc;
      end
    end
    return coef;
  endfunction

  localparam logic [63:0] ANF_FWD = anf_of(SBOX_FWD);
  localparam logic [63:0] ANF_INV = anf_of(SBOX_INV);

  // A monomial lands in tuple t only if every variable it lacks has share index 0 in t.
  function automatic logic tuple_owns(input logic [3:0] t, input logic [3:0] m);
    return (t & ~m) == 4'd0;
  endfunction

endpackage

// File: rtl/prince_sbox_cms_expand.sv
// Combinational CMS expansion of one nibble: two input shares to 16 tuples of 4 bits,
// each tuple touching exactly one share of every input variable.
module prince_sbox_cms_expand
  import prince_cms_pkg::*;
(
  input  logic                    inv,
  input  logic [NIBBLE-1:0]       share0,
  input  logic [NIBBLE-1:0]       share1,
  output logic [NIBBLE*N_EXP-1:0] tuples
);

  logic [63:0] coef;

  assign coef = inv ? ANF_INV : ANF_FWD;

  // Tuple index bit v selects which share of variable v feeds that tuple.
  always_comb begin
    logic       prod;
    logic [3:0] tv;
    logic [3:0] mv;
    tuples = '0;
    prod   = 1'b0;
    tv     = '0;
    mv     = '0;
    for (int t = 0; t < N_EXP; t++) begin
      tv = 4'(t);
      for (int b = 0; b < NIBBLE; b++) begin
        for (int m = 0; m < N_MONO; m++) begin
          mv = 4'(m);
          if (coef[16*b+m] && tuple_owns(tv, mv)) begin
            prod = 1'b1;
            for (int v = 0; v < NIBBLE; v++)
              if (mv[v]) prod = prod & (tv[v] ? share1[v] : share0[v]);
            tuples[4*t+b] = tuples[4*t+b] ^ prod;
          end
        end
      end
    end
  end

endmodule

// File: rtl/prince_sbox_cms_pipe.sv
// Two-stage first-order CMS-masked PRINCE S-box layer: registered 16-share expansion,
// then compression back to two shares with fresh randomness, under a global stall.
module prince_sbox_cms_pipe
  import prince_cms_pkg::*;
#(
  parameter int N_SBOX = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_inv,
  input  logic [NIBBLE*N_SBOX-1:0] in_share0,
  input  logic [NIBBLE*N_SBOX-1:0] in_share1,
  input  logic [NIBBLE*N_SBOX-1:0] in_rnd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIBBLE*N_SBOX-1:0] out_share0,
  output logic [NIBBLE*N_SBOX-1:0] out_share1
);

  localparam int W  = NIBBLE * N_SBOX;
  localparam int LW = NIBBLE * N_EXP;
  localparam int EW = LW * N_SBOX;

  logic          adv;
  logic          s1_valid;
  logic [W-1:0]  s1_rnd;
  logic [EW-1:0] exp_d;
  logic [EW-1:0] s1_exp;
  logic [W-1:0]  comp0;
  logic [W-1:0]  comp1;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar i = 0; i < N_SBOX; i++) begin : g_lane
    logic [NIBBLE-1:0] c0;
    logic [NIBBLE-1:0] c1;

    prince_sbox_cms_expand u_expand (
      .inv    (in_inv),
      .share0 (in_share0[NIBBLE*i +: NIBBLE]),
      .share1 (in_share1[NIBBLE*i +: NIBBLE]),
      .tuples (exp_d[LW*i +: LW])
    );

    // Tuples with x share index 0 fold into share 0, the rest into share 1.
    always_comb begin
      c0 = '0;
      c1 = '0;
      for (int t = 0; t < N_EXP/2; t++) begin
        c0 = c0 ^ s1_exp[LW*i + NIBBLE*t +: NIBBLE];
        c1 = c1 ^ s1_exp[LW*i + NIBBLE*(t + N_EXP/2) +: NIBBLE];
      end
    end

    assign comp0[NIBBLE*i +: NIBBLE] = c0;
    assign comp1[NIBBLE*i +: NIBBLE] = c1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_rnd     <= '0;
      s1_exp     <= '0;
      out_valid  <= 1'b0;
      out_share0 <= '0;
      out_share1 <= '0;
    end else if (adv) begin
      s1_valid   <= in_valid;
      s1_rnd     <= in_rnd;
      s1_exp     <= exp_d;
      out_valid  <= s1_valid;
      out_share0 <= comp0 ^ s1_rnd;
      out_share1 <= comp1 ^ s1_rnd;
    end
  end

endmodule

// File: tb/tb_prince_sbox_cms_pipe.sv
// Randomised bench for prince_sbox_cms_pipe: a table-lookup scoreboard checks the
// unmasked result of every emitted vector, plus latency, stall and reset behaviour.
module tb_prince_sbox_cms_pipe;

  localparam int N = 16;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [W-1:0] in_share0;
  logic [W-1:0] in_share1;
  logic [W-1:0] in_rnd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_share0;
  logic [W-1:0] out_share1;

  int assertCount = 0;
  int failCount   = 0;
  int emitCount   = 0;
  int stallCount  = 0;

  logic [W-1:0] sb[$];

  int sFwd[16] = '{11, 15, 3, 2, 10, 12, 9, 1, 6, 7, 8, 0, 14, 5, 13, 4};
  int sInv[16] = '{11, 7, 3, 2, 15, 13, 8, 9, 10, 6, 4, 0, 5, 14, 12, 1};

  always #5 clk = ~clk;

  prince_sbox_cms_pipe #(.N_SBOX(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inv     (in_inv),
    .in_share0  (in_share0),
    .in_share1  (in_share1),
    .in_rnd     (in_rnd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_share0 (out_share0),
    .out_share1 (out_share1)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] refSbox(input logic [W-1:0] x, input logic inv);
    logic [W-1:0] y;
    y = '0;
    for (int i = 0; i < N; i++)
      y[4*i +: 4] = inv ? 4'(sInv[x[4*i +: 4]]) : 4'(sFwd[x[4*i +: 4]]);
    return y;
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Scoreboard: handshakes are judged at the negedge before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        emitCount++;
        if (sb.size() == 0) checkOutput("unexpected_output", 64'd1, 64'd0);
        else checkOutput("xor_result", out_share0 ^ out_share1, sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(refSbox(in_share0 ^ in_share1, in_inv));
    end
  end

  task automatic applyStimulus(input logic inv, input logic [W-1:0] s0, input logic [W-1:0] s1,
                               input logic [W-1:0] rnd);
    int   budget;
    logic acc;
    budget    = 20;
    acc       = 1'b0;
    in_valid  = 1'b1;
    in_inv    = inv;
    in_share0 = s0;
    in_share1 = s1;
    in_rnd    = rnd;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) stallCount++;
      @(posedge clk);
      #1;
      budget--;
    end
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [W-1:0] s0, s1, ra, rb, xr, oA, oB;
  logic [W-1:0] d0[3], d1[3], dr[3];
  logic         di[3];
  logic [3:0]   probe;
  int           accepted, emitBefore, stallBefore;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_share0 = '0;
    in_share1 = '0;
    in_rnd    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_share0", out_share0, 64'd0);
    checkOutput("reset_share1", out_share1, 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    idle(1);

    // Single transaction: lane 0 carries 0x5 split as 0x5/0x0 with mask 0x9.
    s0 = rand64(); s0[3:0] = 4'h5;
    s1 = rand64(); s1[3:0] = 4'h0;
    ra = rand64(); ra[3:0] = 4'h9;
    applyStimulus(1'b0, s0, s1, ra);
    in_valid = 1'b0;
    checkOutput("lat1_not_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("lat2_valid", 64'(out_valid), 64'd1);
    xr = out_share0 ^ out_share1;
    checkOutput("lat2_lane0", 64'(xr[3:0]), 64'hC);
    idle(2);

    // Every value with every share-0 split, both directions, back to back.
    for (int v = 0; v < 16; v++) begin
      for (int inv = 0; inv < 2; inv++) begin
        for (int i = 0; i < N; i++) begin
          s0[4*i +: 4] = 4'(i);
          s1[4*i +: 4] = 4'(v ^ i);
        end
        applyStimulus(inv[0], s0, s1, rand64());
      end
    end
    idle(3);
    checkOutput("sweep_drained", 64'(sb.size()), 64'd0);

    // Backpressure: three offered while the sink is blocked.
    for (int k = 0; k < 3; k++) begin
      d0[k] = rand64(); d1[k] = rand64(); dr[k] = rand64(); di[k] = $urandom_range(0, 1);
    end
    emitBefore = emitCount;
    out_ready  = 1'b0;
    accepted   = 0;
    in_valid   = 1'b1;
    in_inv = di[0]; in_share0 = d0[0]; in_share1 = d1[0]; in_rnd = dr[0];
    repeat (6) begin
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk);
      #1;
      if (accepted < 3) begin
        in_inv = di[accepted]; in_share0 = d0[accepted]; in_share1 = d1[accepted]; in_rnd = dr[accepted];
      end
    end
    checkOutput("stall_accepted", 64'(accepted), 64'd2);
    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    checkOutput("stall_valid", 64'(out_valid), 64'd1);
    checkOutput("stall_head", out_share0 ^ out_share1, refSbox(d0[0] ^ d1[0], di[0]));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("stall_hold", out_share0 ^ out_share1, refSbox(d0[0] ^ d1[0], di[0]));
    out_ready = 1'b1;
    applyStimulus(di[2], d0[2], d1[2], dr[2]);
    idle(4);
    checkOutput("stall_no_loss", 64'(sb.size()), 64'd0);
    checkOutput("stall_emits", 64'(emitCount - emitBefore), 64'd3);

    // Mode flips every cycle at full rate.
    emitBefore  = emitCount;
    stallBefore = stallCount;
    for (int n = 0; n < 40; n++) applyStimulus(n[0], rand64(), rand64(), rand64());
    idle(3);
    checkOutput("alt_no_stall", 64'(stallCount - stallBefore), 64'd0);
    checkOutput("alt_emits", 64'(emitCount - emitBefore), 64'd40);

    // Same unmasked input under two masks.
    s0 = rand64(); s1 = rand64(); ra = rand64(); rb = rand64();
    applyStimulus(1'b0, s0, s1, ra);
    probe = dut.s1_exp[3:0];
    checkOutput("probe_tuple0", 64'(probe), 64'(sFwd[s0[3:0]]));
    applyStimulus(1'b0, s0, s1, rb);
    in_valid = 1'b0;
    oA = out_share0;
    @(posedge clk);
    #1;
    oB = out_share0;
    checkOutput("rnd_delta", oA ^ oB, ra ^ rb);
    idle(2);

    // Reset while the pipe is full.
    for (int n = 0; n < 4; n++) applyStimulus($urandom_range(0, 1), rand64(), rand64(), rand64());
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_share0", out_share0, 64'd0);
    checkOutput("midrst_share1", out_share1, 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_reset_quiet", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    emitBefore = emitCount;
    applyStimulus(1'b1, rand64(), rand64(), rand64());
    idle(3);
    checkOutput("post_reset_emits", 64'(emitCount - emitBefore), 64'd1);
    checkOutput("post_reset_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
